// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: default widths and the master state encoding.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 12;
  localparam int unsigned BUS_DATA_W = 8;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_REQ,
    MS_ADDR,
    MS_WDATA,
    MS_WACK,
    MS_RWAIT,
    MS_RDATA,
    MS_DONE
  } master_state_e;

endpackage

// File: rtl/master_port_serial_shifter.sv
// LSB-first shift register with bit counter; shared by TX address, TX data and RX data paths.
module serial_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic             lsb,
  output logic             last
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {shift_in, data[WIDTH-1:1]};
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

  assign lsb  = data[0];
  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/master_port.sv
// Serial system-bus master endpoint: parallel requests in, LSB-first address/data out, read bytes back.
// Define MASTER_PORT_BURST_EN to honour req_len and drive tx_burst; otherwise every transaction is one beat.
module master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              read_en,
  output logic              write_en,
  output logic              master_valid,
  output logic              master_ready,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  input  logic              slave_ready,
  input  logic              slave_valid,
  input  logic              rx_data,
  input  logic              slave_rx_done
);

  master_state_e state, state_nxt;

  logic is_write;
  logic accept;
  logic active;
  logic more_beats;
  logic rx_full;

  logic addr_load, addr_shift, addr_lsb, addr_last;
  logic tx_load, tx_shift, tx_lsb, tx_last;
  logic rx_shift, rx_last;

  logic [ADDR_W-1:0] unused_addr_bits;
  logic [DATA_W-1:0] unused_tx_bits;
  logic              unused_rx_lsb;

  serial_shifter #(.WIDTH(ADDR_W)) u_addr_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (addr_load),
    .load_data (req_addr),
    .shift     (addr_shift),
    .shift_in  (1'b0),
    .data      (unused_addr_bits),
    .lsb       (addr_lsb),
    .last      (addr_last)
  );

  serial_shifter #(.WIDTH(DATA_W)) u_tx_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (wdata),
    .shift     (tx_shift),
    .shift_in  (1'b0),
    .data      (unused_tx_bits),
    .lsb       (tx_lsb),
    .last      (tx_last)
  );

  serial_shifter #(.WIDTH(DATA_W)) u_rx_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift     (rx_shift),
    .shift_in  (rx_data),
    .data      (rsp_rdata),
    .lsb       (unused_rx_lsb),
    .last      (rx_last)
  );

  assign accept = (state == MS_IDLE) && req_valid;
  assign active = (state != MS_IDLE) && (state != MS_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MS_IDLE;
      is_write <= 1'b0;
      rx_full  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        is_write <= req_write;
      // A completed byte holds RDATA one extra cycle so rsp_valid precedes done.
      if (rx_shift && rx_last)
        rx_full <= 1'b1;
      else if (state == MS_RDATA && rx_full)
        rx_full <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_load   = 1'b0;
    addr_shift  = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    wdata_ready = 1'b0;
    case (state)
      MS_IDLE: begin
        if (req_valid) begin
          addr_load = 1'b1;
          state_nxt = MS_REQ;
          if (req_write) begin
            tx_load     = 1'b1;
            wdata_ready = 1'b1;
          end
        end
      end
      MS_REQ: begin
        if (slave_ready)
          state_nxt = MS_ADDR;
      end
      MS_ADDR: begin
        addr_shift = 1'b1;
        tx_shift   = is_write;
        if (addr_last)
          state_nxt = is_write ? MS_WACK : MS_RWAIT;
      end
      MS_WACK: begin
        if (slave_rx_done) begin
          if (more_beats) begin
            tx_load     = 1'b1;
            wdata_ready = 1'b1;
            state_nxt   = MS_WDATA;
          end else begin
            state_nxt = MS_DONE;
          end
        end
      end
      MS_WDATA: begin
        tx_shift = 1'b1;
        if (tx_last)
          state_nxt = MS_WACK;
      end
      MS_RWAIT: begin
        if (slave_valid) begin
          rx_shift  = 1'b1;
          state_nxt = MS_RDATA;
        end
      end
      MS_RDATA: begin
        if (rx_full)
          state_nxt = more_beats ? MS_RWAIT : MS_DONE;
        else if (slave_valid)
          rx_shift = 1'b1;
      end
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
  end

`ifdef MASTER_PORT_BURST_EN
  logic [3:0] beat;
  logic       burst;
  logic       beat_dec;

  assign beat_dec = more_beats &&
                    ((state == MS_WACK && slave_rx_done) || (state == MS_RDATA && rx_full));

  always_ff @(posedge clk) begin
    if (reset) begin
      beat  <= '0;
      burst <= 1'b0;
    end else if (accept) begin
      beat  <= req_len;
      burst <= (req_len != '0);
    end else begin
      if (beat_dec)
        beat <= beat - 4'd1;
      if (state == MS_DONE)
        burst <= 1'b0;
    end
  end

  assign more_beats = (beat != '0);
  assign tx_burst   = burst && active;
`else
  logic unused_len;

  assign unused_len = ^req_len;
  assign more_beats = 1'b0;
  assign tx_burst   = 1'b0;
`endif

  assign req_ready    = (state == MS_IDLE);
  assign done         = (state == MS_DONE);
  assign rsp_valid    = rx_full;
  assign read_en      = active && !is_write;
  assign write_en     = active && is_write;
  assign master_valid = (state == MS_ADDR) || (state == MS_WDATA);
  assign master_ready = (state == MS_RWAIT) || (state == MS_RDATA && !rx_full);
  assign tx_address   = (state == MS_ADDR) && addr_lsb;
  assign tx_data      = ((state == MS_ADDR && is_write) || state == MS_WDATA) && tx_lsb;

endmodule
